// File: rtl/bpsk_demod_rx_if.sv
// Sample/bit handshake bundle for bpsk_demod_rx: carrier samples in, recovered bits
// and FIFO status out. The master modport is the driving/draining side.
interface bpsk_demod_rx_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sync;
    logic        rEN;
    logic        dOut;
    logic        dOut_valid;
    logic        bFull;
    logic        bEmpty;
    logic        overflow;

    modport master (
        output sample_in, sample_valid, sync, rEN,
        input  dOut, dOut_valid, bFull, bEmpty, overflow
    );

    modport slave (
        input  sample_in, sample_valid, sync, rEN,
        output dOut, dOut_valid, bFull, bEmpty, overflow
    );
endinterface

// File: rtl/bpsk_demod_rx.sv
// BPSK receiver: correlates each bit period against a +1/-1 half-period reference,
// slices to a hard bit and queues it in a bit FIFO. Sticky overflow flag: BPSK_DEMOD_RX_OVF_EN.
module bpsk_demod_rx #(
    parameter int SPB   = 16,
    parameter int DEPTH = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    bpsk_demod_rx_if.slave bus
);
    localparam int IW = $clog2(SPB);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACC} state_t;

    state_t             state_reg;
    logic [IW-1:0]      idx_reg;
    logic signed [23:0] sum_reg;
    logic [AW:0]        wr_ptr_reg, rd_ptr_reg;
    logic               mem [DEPTH];
    logic               dout_reg, dout_valid_reg;

    logic               restart;
    logic [IW-1:0]      eff_idx;
    logic signed [23:0] sample_ext, term, base_sum, sum_full;
    logic               last, dec_fire, bit_dec, full, empty, wr_fire, rd_fire;

    // IDLE and sync both start a fresh period, so the current sample sits at index 0.
    always_comb begin
        restart    = (state_reg == IDLE) || bus.sync;
        eff_idx    = restart ? '0 : idx_reg;
        base_sum   = restart ? 24'sd0 : sum_reg;
        sample_ext = {{8{bus.sample_in[15]}}, bus.sample_in};
        term       = eff_idx[IW-1] ? -sample_ext : sample_ext;
        sum_full   = base_sum + term;
        last       = (eff_idx == IW'(SPB - 1));
        dec_fire   = bus.sample_valid && last;
        bit_dec    = ~sum_full[23];
    end

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign wr_fire = dec_fire && !full;
    assign rd_fire = bus.rEN && !empty;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            sum_reg   <= '0;
        end else begin
            if (restart && (bus.sync || bus.sample_valid))
                state_reg <= ACC;
            if (bus.sample_valid) begin
                if (last) begin
                    idx_reg <= '0;
                    sum_reg <= '0;
                end else begin
                    idx_reg <= eff_idx + IW'(1);
                    sum_reg <= sum_full;
                end
            end else if (bus.sync) begin
                idx_reg <= '0;
                sum_reg <= '0;
            end
        end
    end

    // Storage has no reset; emptiness is defined purely by the pointers.
    always_ff @(posedge CLK) begin
        if (wr_fire)
            mem[wr_ptr_reg[AW-1:0]] <= bit_dec;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            dout_reg       <= 1'b0;
            dout_valid_reg <= 1'b0;
        end else begin
            if (wr_fire)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_fire) begin
                dout_reg   <= mem[rd_ptr_reg[AW-1:0]];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            dout_valid_reg <= rd_fire;
        end
    end

`ifdef BPSK_DEMOD_RX_OVF_EN
    logic ovf_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            ovf_reg <= 1'b0;
        else if (dec_fire && full)
            ovf_reg <= 1'b1;
    end

    assign bus.overflow = ovf_reg;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.dOut       = dout_reg;
    assign bus.dOut_valid = dout_valid_reg;
    assign bus.bFull      = full;
    assign bus.bEmpty     = empty;
endmodule

// File: tb/tb_bpsk_demod_rx.sv
// Directed bench for bpsk_demod_rx (SPB=16, DEPTH=8): bit slicing, gaps, sync,
// full/overflow, simultaneous read/write, wrap-around and asynchronous reset.
module tb_bpsk_demod_rx;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   errors = 0;
    int   checks = 0;

`ifdef BPSK_DEMOD_RX_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    bpsk_demod_rx_if bus ();

    bpsk_demod_rx #(.SPB(16), .DEPTH(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One bit period: first half +amp for bit 1 (-amp for bit 0), second half negated.
    task automatic send_bit(input bit b, input bit sync_first, input bit rd_last,
                            input bit gaps, input bit chk_pre, input int amp);
        for (int i = 0; i < 16; i++) begin
            if (chk_pre && i == 15) check("pre_decision_empty", bus.bEmpty, 1);
            bus.sample_in    = (((i < 8) ? 1'b1 : 1'b0) == b) ? 16'(amp) : 16'(-amp);
            bus.sample_valid = 1'b1;
            bus.sync         = sync_first && (i == 0);
            bus.rEN          = rd_last && (i == 15);
            cyc();
            bus.sample_valid = 1'b0;
            bus.sync         = 1'b0;
            bus.rEN          = 1'b0;
            if (gaps) cyc();
        end
        $display("bit sent: value=%0b sync=%0b rd=%0b gaps=%0b", b, sync_first, rd_last, gaps);
    endtask

    task automatic read_bit(input string tag, input logic exp);
        bus.rEN = 1'b1;
        cyc();
        bus.rEN = 1'b0;
        check({tag, "_valid"}, bus.dOut_valid, 1);
        check(tag, bus.dOut, exp);
        $display("read: dOut=%0b expected=%0b", bus.dOut, exp);
    endtask

    initial begin
        logic [8:0]  nine;
        logic [19:0] pat;
        logic        q [$];
        logic        exp_bit;

        bus.sample_in = '0; bus.sample_valid = 0; bus.sync = 0; bus.rEN = 0;
        nine = 9'b1_0100_1101;   // bits 1,0,1,1,0,0,1,0,1 sent from LSB
        pat  = 20'b1011_0010_1110_0101_0011;

        repeat (2) cyc();
        check("rst_empty", bus.bEmpty, 1);
        check("rst_full", bus.bFull, 0);
        check("rst_dout", bus.dOut, 0);
        check("rst_dvalid", bus.dOut_valid, 0);
        check("rst_ovf", bus.overflow, 0);
        RESET = 1'b1;
        cyc();

        // Bit 1, continuous samples
        send_bit(1'b1, 0, 0, 0, 1, 1000);
        check("bit1_empty", bus.bEmpty, 0);
        read_bit("bit1_dout", 1'b1);
        cyc();
        check("bit1_dvalid_clear", bus.dOut_valid, 0);
        check("bit1_drained", bus.bEmpty, 1);

        // Bit 0 with a gap after every sample
        send_bit(1'b0, 0, 0, 1, 1, 500);
        check("bit0_empty", bus.bEmpty, 0);
        read_bit("bit0_dout", 1'b0);

        // sync alone after 5 samples discards the partial bit
        for (int i = 0; i < 5; i++) begin
            bus.sample_in = -16'sd1000; bus.sample_valid = 1'b1;
            cyc();
        end
        bus.sample_valid = 1'b0; bus.sync = 1'b1;
        cyc();
        bus.sync = 1'b0;
        send_bit(1'b1, 0, 0, 0, 1, 1000);
        read_bit("sync_dout", 1'b1);
        check("sync_one_entry", bus.bEmpty, 1);

        // sync together with a valid sample: that sample is index 0
        for (int i = 0; i < 5; i++) begin
            bus.sample_in = -16'sd1000; bus.sample_valid = 1'b1;
            cyc();
        end
        send_bit(1'b1, 1, 0, 0, 1, 1000);
        read_bit("syncv_dout", 1'b1);
        check("syncv_one_entry", bus.bEmpty, 1);

        // Nine bits without reads: fill, then drop the ninth
        for (int k = 0; k < 9; k++) begin
            send_bit(nine[k], 0, 0, 0, 0, 1000);
            if (k == 6) check("fill7_full", bus.bFull, 0);
            if (k == 7) begin
                check("fill8_full", bus.bFull, 1);
                check("fill8_ovf", bus.overflow, 0);
            end
        end
        check("drop9_full", bus.bFull, 1);
        check("drop9_ovf", bus.overflow, OVF_EXP);

        // Read and decision in the same cycle while full: read wins, write dropped
        send_bit(1'b1, 0, 1, 0, 0, 1000);
        check("full_rw_dvalid", bus.dOut_valid, 1);
        check("full_rw_dout", bus.dOut, 1);
        check("full_rw_notfull", bus.bFull, 0);
        for (int k = 1; k < 8; k++) read_bit("drain_dout", nine[k]);
        check("drain_empty", bus.bEmpty, 1);

        // Read request while empty is ignored
        bus.rEN = 1'b1;
        cyc();
        bus.rEN = 1'b0;
        check("drain_extra_ignored", bus.dOut_valid, 0);
        $display("read while empty: dOut_valid=%0b expected=0", bus.dOut_valid);
        check("ovf_sticky", bus.overflow, OVF_EXP);

        // Simultaneous read and write while empty: only the write happens
        send_bit(1'b1, 0, 1, 0, 0, 1000);
        check("empty_rw_dvalid", bus.dOut_valid, 0);
        check("empty_rw_written", bus.bEmpty, 0);
        q.push_back(1'b1);
        send_bit(1'b0, 0, 0, 0, 0, 1000);
        q.push_back(1'b0);

        // Wrap-around: each new decision coincides with a read of the oldest bit
        for (int k = 0; k < 20; k++) begin
            send_bit(pat[k], 0, 1, 0, 0, 1000);
            exp_bit = q.pop_front();
            q.push_back(pat[k]);
            check("wrap_dvalid", bus.dOut_valid, 1);
            check("wrap_dout", bus.dOut, exp_bit);
        end
        send_bit(1'b1, 0, 0, 0, 0, 1000);
        check("three_queued", bus.bEmpty, 0);

        // Asynchronous reset mid-queue
        RESET = 1'b0;
        #1;
        check("arst_empty", bus.bEmpty, 1);
        check("arst_full", bus.bFull, 0);
        check("arst_dout", bus.dOut, 0);
        check("arst_ovf", bus.overflow, 0);
        cyc();
        RESET = 1'b1;
        bus.rEN = 1'b1;
        cyc();
        bus.rEN = 1'b0;
        check("arst_no_read", bus.dOut_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bpsk_demod_rx.md
# bpsk_demod_rx

Receive-side counterpart of the serial-bit FIFO and sine modulator. It takes the 16-bit signed sample stream produced by the modulator, correlates each bit period against a one-cycle reference, and slices each period into a hard bit. Recovered bits go into an 8-entry bit FIFO, which downstream logic drains with a read-enable handshake.

## Interface
- `SPB`, default 16: samples per bit; a power of two from 4 to 32.
- `DEPTH`, default 8: FIFO entries; a power of two.
- `CLK`, input, 1: the only clock; all state changes on the rising edge.
- `RESET`, input, 1: asynchronous, active-low reset.
- `sample_in`, input, 16: signed two's-complement carrier sample.
- `sample_valid`, input, 1: `sample_in` is valid this cycle.
- `sync`, input, 1: bit-boundary pulse; realigns the correlator.
- `rEN`, input, 1: read request for one recovered bit.
- `dOut`, output, 1: recovered bit, registered.
- `dOut_valid`, output, 1: one-cycle pulse; `dOut` updated this cycle.
- `bFull`, output, 1: FIFO holds `DEPTH` bits.
- `bEmpty`, output, 1: FIFO holds no bits.
- `overflow`, output, 1: sticky flag; a decided bit was dropped because the FIFO was full.

## Operation
- Carrier convention: one sine cycle per bit period. Bit 1 uses 0° phase; bit 0 uses 180° phase.
- Reference: +1 for sample indices 0 to `SPB`/2-1, and −1 for indices `SPB`/2 to `SPB`-1.
- Accumulator: 24-bit signed. Each accepted sample adds its sign-extended value times the reference.
- No overflow is possible, since 16 + log2(32) + 1 = 22 bits is below the 24-bit width.
- States:
  - IDLE: the first `sample_valid` moves to ACC, with that sample taken as index 0.
  - ACC: counts accepted samples. On the `SPB`-th sample, the decision is made and the block stays in ACC with the index reset to 0.
- Decision: the bit is 1 when the final sum (including the last sample's term) is ≥ 0, and 0 otherwise. The sum is cleared for the next period.
- `sample_valid` low during ACC: index and sum hold, so the bit period stretches over gaps.
- `sync` high: clears index and sum and moves to ACC. If `sample_valid` is also high, that sample becomes index 0. The partial bit is discarded and nothing is written.
- FIFO pointers:
  - Write and read pointers are log2(`DEPTH`)+1 bits wide, carrying a wrap bit.
  - `bEmpty` = pointers equal.
  - `bFull` = address bits equal and wrap bits differ.
  - Both flags are combinational from the registered pointers.
- Write: a decided bit is written when `bFull` is low. When `bFull` is high, the bit is dropped and `overflow` is set.
- Read: when `rEN` and not `bEmpty`, `dOut` takes the head entry and the read pointer advances. `rEN` while empty is ignored.
- Simultaneous read and write:
  - Both take effect.
  - If full, the write is still dropped, because `bFull` is evaluated before the read.
  - If empty, only the write occurs.

## Timing
- Reset values: state IDLE, index 0, sum 0, pointers 0, `dOut` 0, `dOut_valid` 0, `bEmpty` 1, `bFull` 0, `overflow` 0.
- Reset mid-bit: the partial sum is lost and the FIFO is emptied immediately, asynchronously.
- Decision latency: the `SPB`-th sample is accepted at edge N. The entry is written at edge N, and `bEmpty` falls after edge N.
- Read latency: with `rEN` sampled at edge N, `dOut` and `dOut_valid` = 1 appear after edge N. `dOut_valid` clears after edge N+1 unless another read occurs.
- Throughput: one read per cycle and one decision per `SPB` accepted samples.
- `overflow` clears only on reset.

## Configuration
- `BPSK_DEMOD_RX_OVF_EN` defined: the sticky `overflow` logic is compiled in.
- `BPSK_DEMOD_RX_OVF_EN` undefined:
  - `overflow` is tied to 0.
  - Writes while full are still dropped silently.

## Test plan
All scenarios use `SPB`=16 and `DEPTH`=8.
- Reset then idle: `bEmpty`=1, `bFull`=0, `dOut`=0, `dOut_valid`=0, `overflow`=0.
- Bit 1: 8 samples of +1000 then 8 of −1000, `sample_valid` continuous → sum +16000. After the 16th sample `bEmpty`=0; `rEN` pulse → `dOut`=1, `dOut_valid`=1 for one cycle.
- Bit 0 with gaps: 8 samples of −500 then 8 of +500, `sample_valid` low every other cycle → decision after 16 accepted samples; read gives `dOut`=0.
- `sync` after 5 samples, then 16 samples of bit-1 pattern → exactly one entry, value 1.
- Nine back-to-back bits 1,0,1,1,0,0,1,0,1 with no reads:
  - `bFull`=1 after the 8th bit, and the 9th bit is dropped.
  - `overflow`=1 when the macro is defined, 0 when undefined.
  - Eight reads then return 1,0,1,1,0,0,1,0 and `bEmpty`=1.
- Wrap-around: 20 bits written and read interleaved → read order matches write order. Assert `RESET` while 3 bits are queued → `bEmpty`=1 immediately, and `rEN` yields no `dOut_valid`.
